// File: rtl/data_mem_pkg.sv
// Shared encodings for the data memory: load/store control codes, MMIO register
// offsets and the mtimecmp reset value.
package data_mem_pkg;

  localparam logic [2:0] RD_NONE = 3'b000;
  localparam logic [2:0] RD_LB   = 3'b001;
  localparam logic [2:0] RD_LBU  = 3'b010;
  localparam logic [2:0] RD_LH   = 3'b011;
  localparam logic [2:0] RD_LHU  = 3'b100;
  localparam logic [2:0] RD_LW   = 3'b101;
  localparam logic [2:0] RD_LWU  = 3'b110;
  localparam logic [2:0] RD_LD   = 3'b111;

  localparam logic [2:0] WR_NONE = 3'b000;
  localparam logic [2:0] WR_SB   = 3'b001;
  localparam logic [2:0] WR_SH   = 3'b010;
  localparam logic [2:0] WR_SW   = 3'b011;
  localparam logic [2:0] WR_SD   = 3'b100;

  localparam logic [63:0] MMIO_MTIME    = 64'h00;
  localparam logic [63:0] MMIO_MTIMECMP = 64'h08;
  localparam logic [63:0] MMIO_TOHOST   = 64'h10;
  localparam logic [63:0] MMIO_SPAN     = 64'h18;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/dm_lane.sv
// Byte-lane logic shared by RAM and MMIO: store byte merge, load extraction with
// sign/zero extension, and alignment checks for both directions.
module dm_lane
  import data_mem_pkg::*;
(
  input  logic [63:0] old_word,
  input  logic [63:0] din,
  input  logic [2:0]  addr_lo,
  input  logic [2:0]  rd_ctrl,
  input  logic [2:0]  wr_ctrl,
  output logic [63:0] st_word,
  output logic [63:0] ld_data,
  output logic        ld_mis,
  output logic        st_mis
);

  logic [5:0]  shamt;
  logic [63:0] shifted;
  logic [63:0] wr_data;
  logic [7:0]  base_mask;
  logic [7:0]  wr_mask;

  assign shamt   = {addr_lo, 3'b000};
  assign shifted = old_word >> shamt;
  assign wr_data = din << shamt;

  always_comb begin
    ld_mis  = 1'b0;
    ld_data = '0;
    case (rd_ctrl)
      RD_LB:  ld_data = {{56{shifted[7]}}, shifted[7:0]};
      RD_LBU: ld_data = {56'd0, shifted[7:0]};
      RD_LH: begin
        ld_mis  = addr_lo[0];
        ld_data = {{48{shifted[15]}}, shifted[15:0]};
      end
      RD_LHU: begin
        ld_mis  = addr_lo[0];
        ld_data = {48'd0, shifted[15:0]};
      end
      RD_LW: begin
        ld_mis  = |addr_lo[1:0];
        ld_data = {{32{shifted[31]}}, shifted[31:0]};
      end
      RD_LWU: begin
        ld_mis  = |addr_lo[1:0];
        ld_data = {32'd0, shifted[31:0]};
      end
      RD_LD: begin
        ld_mis  = |addr_lo;
        ld_data = shifted;
      end
      default: ld_data = '0;
    endcase
    // A misaligned load reads as zero rather than a partial word.
    if (ld_mis) ld_data = '0;
  end

  always_comb begin
    st_mis    = 1'b0;
    base_mask = 8'h00;
    case (wr_ctrl)
      WR_SB: base_mask = 8'h01;
      WR_SH: begin
        base_mask = 8'h03;
        st_mis    = addr_lo[0];
      end
      WR_SW: begin
        base_mask = 8'h0F;
        st_mis    = |addr_lo[1:0];
      end
      WR_SD: begin
        base_mask = 8'hFF;
        st_mis    = |addr_lo;
      end
      default: base_mask = 8'h00;
    endcase
    wr_mask = base_mask << addr_lo;
    st_word = old_word;
    for (int b = 0; b < 8; b++) begin
      if (wr_mask[b]) st_word[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/data_mem.sv
// 64-bit data memory with combinational loads, byte-merged stores and sticky
// misalignment capture. Define DM_MMIO_EN to add the mtime/mtimecmp/tohost window.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int          DEPTH     = 512,
  parameter logic [63:0] MMIO_BASE = 64'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  dm_rd_ctrl,
  input  logic [2:0]  dm_wr_ctrl,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_din,
  output logic [63:0] dm_dout,
  output logic        misalign,
  output logic [63:0] err_addr,
  output logic        timer_irq,
  output logic        halt
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [63:0]   old_word;
  logic [63:0]   st_word;
  logic          ld_mis;
  logic          st_mis;
  logic          st_valid;
  logic          wr_en;
  logic          mmio_hit;
  logic [63:0]   mmio_word;

  assign idx      = dm_addr[3 +: AW];
  assign st_valid = (dm_wr_ctrl != WR_NONE) && (dm_wr_ctrl <= WR_SD);
  assign wr_en    = st_valid && !st_mis && !rst;
  assign old_word = mmio_hit ? mmio_word : mem[idx];

  dm_lane u_lane (
    .old_word (old_word),
    .din      (dm_din),
    .addr_lo  (dm_addr[2:0]),
    .rd_ctrl  (dm_rd_ctrl),
    .wr_ctrl  (dm_wr_ctrl),
    .st_word  (st_word),
    .ld_data  (dm_dout),
    .ld_mis   (ld_mis),
    .st_mis   (st_mis)
  );

  // RAM has no reset; read-before-write falls out of the combinational read path.
  always_ff @(posedge clk) begin
    if (wr_en && !mmio_hit) mem[idx] <= st_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign <= 1'b0;
      err_addr <= '0;
    end else if ((ld_mis || st_mis) && !misalign) begin
      misalign <= 1'b1;
      err_addr <= dm_addr;
    end
  end

`ifdef DM_MMIO_EN
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [63:0] tohost;
  logic [63:0] mmio_off;

  assign mmio_off  = dm_addr - MMIO_BASE;
  assign mmio_hit  = mmio_off < MMIO_SPAN;
  assign timer_irq = mtime >= mtimecmp;

  always_comb begin
    mmio_word = tohost;
    case (mmio_off[4:3])
      MMIO_MTIME[4:3]:    mmio_word = mtime;
      MMIO_MTIMECMP[4:3]: mmio_word = mtimecmp;
      default:            mmio_word = tohost;
    endcase
  end

  // A store to mtime overrides that cycle's increment (later NBA wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RST;
      tohost   <= '0;
      halt     <= 1'b0;
    end else begin
      mtime <= mtime + 64'd1;
      if (wr_en && mmio_hit) begin
        case (mmio_off[4:3])
          MMIO_MTIME[4:3]:    mtime    <= st_word;
          MMIO_MTIMECMP[4:3]: mtimecmp <= st_word;
          default: begin
            tohost <= st_word;
            if (|st_word) halt <= 1'b1;
          end
        endcase
      end
    end
  end
`else
  logic unused_bits;

  assign mmio_hit    = 1'b0;
  assign mmio_word   = '0;
  assign timer_irq   = 1'b0;
  assign halt        = 1'b0;
  assign unused_bits = ^{dm_addr[63:3+AW], MMIO_BASE};
`endif

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 512, giving the number of 64-bit RAM words (power of two).
REQ-002 SHALL have parameter MMIO_BASE, default 64'h1000_0000, giving the base address of the MMIO window.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port dm_rd_ctrl, input, 3, load type: 000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, 110 LWU, 111 LD.
REQ-006 SHALL have port dm_wr_ctrl, input, 3, store type: 000 none, 001 SB, 010 SH, 011 SW, 100 SD; 101-111 treated as none.
REQ-007 SHALL have port dm_addr, input, 64, byte address.
REQ-008 SHALL have port dm_din, input, 64, store data, right-aligned.
REQ-009 SHALL have port dm_dout, output, 64, load data, extended to 64 bits.
REQ-010 SHALL have port misalign, output, 1, sticky flag for a misaligned access.
REQ-011 SHALL have port err_addr, output, 64, address of the first misaligned access.
REQ-012 SHALL have port timer_irq, output, 1, asserted while mtime >= mtimecmp.
REQ-013 SHALL have port halt, output, 1, sticky flag set by a nonzero tohost store.

Function
REQ-014 Loads SHALL be combinational, so dm_dout is valid in the same cycle as dm_addr/dm_rd_ctrl; dm_dout SHALL be 0 when dm_rd_ctrl=000.
REQ-015 Byte lane SHALL be selected by dm_addr[2:0]; signed loads (LB/LH/LW) SHALL sign-extend and LBU/LHU/LWU SHALL zero-extend.
REQ-016 Stores SHALL commit at the clk edge and write only the addressed bytes; all other bytes of the word SHALL be preserved.
REQ-017 RAM word index SHALL be dm_addr[3 +: log2(DEPTH)]; higher address bits SHALL be ignored, so out-of-range addresses wrap.
REQ-018 A load and a store to the same address in one cycle SHALL return the pre-store data.
REQ-019 If dm_rd_ctrl and dm_wr_ctrl are both nonzero, the store SHALL commit and the load SHALL return old data.
REQ-020 An access SHALL be misaligned when addr[0]≠0 for H, addr[1:0]≠0 for W, or addr[2:0]≠0 for D.
REQ-021 A misaligned store SHALL be suppressed and a misaligned load SHALL return 0.
REQ-022 A misaligned access SHALL set misalign on the next edge; err_addr SHALL be captured only when misalign was 0 (first error wins).
REQ-023 misalign SHALL be cleared only by rst.

Reset
REQ-024 On rst, misalign=0, err_addr=0, halt=0, mtime=0, and mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, giving timer_irq=0.
REQ-025 RAM contents SHALL NOT be reset.
REQ-026 A store presented in a cycle with rst=1 SHALL NOT commit.

Configuration
REQ-027 Macro DM_MMIO_EN SHALL compile in the MMIO window at MMIO_BASE with these registers: +0x00 mtime, +0x08 mtimecmp, +0x10 tohost.
REQ-028 With DM_MMIO_EN defined:
- mtime SHALL increment every cycle and wrap at 2^64.
- A store to mtime SHALL load the merged value in place of the increment for that cycle.
- Sub-doubleword MMIO stores SHALL merge bytes per REQ-016.
- A nonzero value stored to tohost SHALL set halt.
- MMIO loads SHALL follow REQ-015.
- MMIO accesses SHALL NOT touch RAM.
REQ-029 Without DM_MMIO_EN, all addresses SHALL map to RAM per REQ-017, and timer_irq and halt SHALL be tied to 0.

Structure
REQ-030 A shared package SHALL hold the load/store ctrl encodings, the MMIO offsets, and the mtimecmp reset value.
REQ-031 Byte-lane merge and load extension SHALL be one combinational sub-module, dm_lane, shared by the RAM and MMIO paths.

Verification
REQ-032 SD 64'h8877665544332211 to 0x40, then LB/LBU at 0x47 -> 64'hFFFF_FFFF_FFFF_FF88 / 64'h88; LW at 0x44 -> 64'hFFFF_FFFF_8877_6655.
REQ-033 After REQ-032, SH 16'hABCD to 0x42, then LD at 0x40 -> 64'h88776655ABCD2211.
REQ-034 SW to 0x46 -> RAM unchanged; misalign=1 and err_addr=0x46 next cycle; a later LH at 0x01 leaves err_addr=0x46.
REQ-035 With DEPTH=512, SD to 0x1000 then LD at 0x0 -> same data (wrap).
REQ-036 With DM_MMIO_EN: rst, SD mtimecmp=5 -> timer_irq rises when mtime=5; SD tohost=1 -> halt=1 next cycle and stays high until rst.
REQ-037 Reset mid-operation: assert rst in the same cycle as an SD -> target word unchanged and all flags 0.
